// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// All outputs are registered; flush empties both slots to a NOP bubble.
module id_ex_skid_stage #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        NUM_DATA = 4,
  parameter int unsigned        CTRL_W   = 24,
  parameter int unsigned        RD_W     = 5,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [RD_W-1:0]            IN_RD,
  input  logic [NUM_DATA*DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0]          IN_CTRL,
  input  logic                       PC_SEL,
  input  logic                       FLUSH_E,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [RD_W-1:0]            OUT_RD,
  output logic [NUM_DATA*DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0]          OUT_CTRL,
  output logic                       OUT_FLUSHED,
  output logic [1:0]                 OCCUPANCY
);

  localparam int unsigned DW = NUM_DATA * DATA_W;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DW-1:0]     data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam entry_t BUBBLE = entry_t'{
    rd:   '0,
    data: '0,
    ctrl: CTRL_NOP
  };

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   flushed_q, flushed_d;
  logic   in_ready_q, out_valid_q;

  logic   accept, retire, flush;
  entry_t in_e;

  assign in_e   = entry_t'{rd: IN_RD, data: IN_DATA, ctrl: IN_CTRL};
  assign accept = IN_VALID & in_ready_q;
  assign retire = out_valid_q & OUT_READY;
  assign flush  = PC_SEL | FLUSH_E;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    flushed_d = 1'b0;
    if (flush) begin
      // A same-edge retire already belongs to EX, so it is not "lost".
      state_d   = EMPTY;
      main_d    = BUBBLE;
      skid_d    = BUBBLE;
      flushed_d = (state_q == FULL) |
                  ((state_q == HALF) & ~retire);
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = HALF;
            main_d  = in_e;
          end
        end
        HALF: begin
          if (accept && retire) begin
            main_d = in_e;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_e;
          end else if (retire) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end
        end
        FULL: begin
          if (retire) begin
            state_d = HALF;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      flushed_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      flushed_q   <= flushed_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign IN_READY    = in_ready_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_RD      = main_q.rd;
  assign OUT_DATA    = main_q.data;
  assign OUT_CTRL    = main_q.ctrl;
  assign OUT_FLUSHED = flushed_q;
  assign OCCUPANCY   = state_q;

endmodule
